window_3x3_buffer: RTL and testbench
====================================

# window_3x3_buffer

Streaming 3x3 sliding-window generator directly downstream of the pixel normalizer. Consumes one Q8.8 normalized pixel per valid cycle in raster order and, once two full rows plus three pixels of the current frame are buffered, presents a complete 3x3 neighbourhood to the convolution stage. Uses valid-mode (no padding) convolution, so it produces (IMG_W-2)x(IMG_H-2) windows per frame.

## Interface

- IMG_W, 28: pixels per row; at least 3.
- IMG_H, 28: rows per frame; at least 3.
- DATA_W, 16: pixel width, Q8.8, matching the normalizer output.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- valid_in  input  1  pixel_in is valid this cycle. There is no backpressure; every valid cycle is accepted.
- pixel_in  input  DATA_W  normalized pixel.
- valid_out  output  1  window_out holds a complete window.
- window_out  output  9*DATA_W  element (r,c) occupies bits [(r*3+c)*DATA_W +: DATA_W].
  - r=0 is the oldest row; c=0 is the leftmost column.
  - (2,2) is the newest pixel.
- frame_done  output  1  single-cycle pulse with the last window of a frame.

## Operation

- The column counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance only on valid_in.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next pixel starts a new frame.
- Two line delays, each IMG_W deep, provide taps at pixel index n-IMG_W and n-2*IMG_W. They shift only on valid_in.
- The 3x3 register array shifts left on valid_in.
  - Column 2 loads, top to bottom: {tap2, tap1, pixel_in}.
- A window is complete when the accepted pixel has row>=2 and col>=2.
- There is no buffer clear between frames.
  - Row gating guarantees that taps at a new frame's row 2 come from rows 0 and 1 of that frame.
  - Windows never straddle rows, because the col>=2 gate discards columns that wrap from the previous row.
- There is no state machine beyond the counters. States are implied by the row counter: FILL (row<2) and STREAM (row>=2).
- No arithmetic is performed on data. Pixels pass bit-exact.

## Timing

- Reset (rst low, asynchronous) clears:
  - valid_out=0, frame_done=0, window_out=0;
  - counters=0;
  - line-buffer contents (a synchronous clear is not required, but outputs must be 0).
- Latency is 1 cycle. valid_out is high in the cycle after the clock edge that accepted the completing pixel.
- valid_out is high for exactly one cycle per completing pixel.
  - With valid_in low, valid_out deasserts next cycle.
  - window_out holds its last value.
- Gaps in valid_in are allowed anywhere. All state freezes during a gap.
- frame_done is asserted in the same cycle as the valid_out for pixel (IMG_H-1, IMG_W-1).
- Reset mid-frame takes effect immediately. The first valid pixel after release is (0,0), and no window is emitted until row 2, col 2.
- Release of rst is synchronised by the integrator. This block needs no special first-cycle handling.
- Throughput is 1 window per clock at full rate.

## Configuration

- WIN_POS_EN:
  - Defined: adds two output ports.
    - out_row, width $clog2(IMG_H), resets to 0.
    - out_col, width $clog2(IMG_W), resets to 0.
    - They give the centre coordinates of the window, registered alongside window_out (e.g. row=1, col=1 for the first window).
  - Undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure

- cnn_pkg:
  - DATA_W, IMG_W, IMG_H defaults;
  - typedef pixel_t (logic [DATA_W-1:0]);
  - typedef window_t (pixel_t [0:2][0:2]);
  - the pack function for window_out.
  - The normalizer and convolution stages share this package.
- Sub-module line_buffer (parameters DEPTH, DATA_W; ports clk, rst, en, din, dout):
  - a valid-gated delay line;
  - instantiated twice, cascaded.

## Test plan

- **Fill and first window.** Parameters IMG_W=4, IMG_H=4. Pixels n=0..15, value n<<8, continuous valid.
  - First valid_out occurs one cycle after pixel 10.
  - window = {0,1,2,4,5,6,8,9,10}<<8.
  - Exactly 4 windows total.
- **Per-frame window sequence, same run.**
  - Second window = {1,2,3,5,6,7,9,10,11}<<8.
  - No window after pixel 12 or 13.
  - Last window = {5,6,7,9,10,11,13,14,15}<<8, with frame_done high in the same cycle only.
- **Input gaps.** Same stream with valid_in low for 3 random cycles between pixels.
  - Identical window values and order.
  - valid_out never high during a gap.
- **Back-to-back frames.** Second frame values (n+100)<<8 immediately after the first.
  - First window of frame 2 = {100,101,102,104,105,106,108,109,110}<<8.
  - No frame-1 data in it.
- **Mid-frame reset.** rst low for 1 cycle after pixel 9.
  - All outputs read 0 during reset.
  - Restarted frame's first window appears after its 11th pixel.
- **WIN_POS_EN.** Same 4x4 stream with the macro defined.
  - (out_row, out_col) = (1,1), (1,2), (2,1), (2,2) in order.

Source files
------------

// File: rtl/cnn_pkg.sv
// ============================================================================
// Package  : cnn_pkg
// Purpose  : Shared pixel/window types and defaults for the CNN front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t [0:2][0:2] window_t;

  // Element (r,c) lands at bits [(r*3+c)*DATA_W +: DATA_W]
  function automatic logic [9*DATA_W-1:0] pack_window(input window_t w);
    logic [9*DATA_W-1:0] p;
    p = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[(r*3+c)*DATA_W +: DATA_W] = w[r][c];
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_3x3_buffer_line_buffer.sv
// ============================================================================
// Module   : line_buffer
// Purpose  : Enable-gated delay line; dout is the sample DEPTH accepts back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (en) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign dout = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/window_3x3_buffer.sv
// ============================================================================
// Module   : window_3x3_buffer
// Purpose  : Streaming valid-mode 3x3 window generator over raster pixels.
//            Optional macro WIN_POS_EN adds window-centre coordinate outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_3x3_buffer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic                  valid_out,
  output logic [9*DATA_W-1:0]   window_out,
  output logic                  frame_done
`ifdef WIN_POS_EN
  ,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col
`endif
);

  import cnn_pkg::*;

  localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] r_col;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_win_done;
  logic [DATA_W-1:0]  w_tap1;
  logic [DATA_W-1:0]  w_tap2;

  logic [0:2][0:2][DATA_W-1:0] r_win;

  assign w_last_col = (r_col == c_COL_W'(IMG_W-1));
  assign w_last_row = (r_row == c_ROW_W'(IMG_H-1));
  // FILL while row<2; col<2 also drops columns wrapped from the previous row
  assign w_win_done = (r_row >= c_ROW_W'(2)) && (r_col >= c_COL_W'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (valid_in) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + c_ROW_W'(1);
      end else begin
        r_col <= r_col + c_COL_W'(1);
      end
    end
  end

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (valid_in),
    .din  (pixel_in),
    .dout (w_tap1)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line2 (
    .clk  (clk),
    .rst  (rst),
    .en   (valid_in),
    .din  (w_tap1),
    .dout (w_tap2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_tap2;
      r_win[1][2] <= w_tap1;
      r_win[2][2] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= valid_in && w_win_done;
      frame_done <= valid_in && w_last_row && w_last_col;
    end
  end

`ifdef WIN_POS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (valid_in && w_win_done) begin
      out_row <= r_row - c_ROW_W'(1);
      out_col <= r_col - c_COL_W'(1);
    end
  end
`endif

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign window_out[(gr*3+gc)*DATA_W +: DATA_W] = r_win[gr][gc];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_buffer.sv
// ============================================================================
// Module   : tb_window_3x3_buffer
// Purpose  : Self-checking bench for window_3x3_buffer on a 4x4 image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_3x3_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int WW = 9*DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          valid_out;
  logic [WW-1:0] window_out;
  logic          frame_done;
`ifdef WIN_POS_EN
  logic [1:0]    out_row;
  logic [1:0]    out_col;
`endif

  window_3x3_buffer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .pixel_in   (pixel_in),
    .valid_out  (valid_out),
    .window_out (window_out),
    .frame_done (frame_done)
`ifdef WIN_POS_EN
    ,
    .out_row    (out_row),
    .out_col    (out_col)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: position within frame and the frame's pixels
  int            m_n = 0;
  logic [DW-1:0] img [0:W*H-1];
  logic          exp_valid = 1'b0;
  logic          exp_done  = 1'b0;
  logic [WW-1:0] exp_win   = '0;
  int            exp_row   = 0;
  int            exp_col   = 0;
  logic [WW-1:0] obs_q [$];

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [WW-1:0] win_at(input int base, input int tl);
    logic [WW-1:0] p;
    p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[(r*3+c)*DW +: DW] = DW'((base + tl + r*W + c) << 8);
    return p;
  endfunction

  task automatic check_outputs();
    chk("valid_out", WW'(valid_out), WW'(exp_valid));
    chk("frame_done", WW'(frame_done), WW'(exp_done));
    if (exp_valid) begin
      chk("window", window_out, exp_win);
`ifdef WIN_POS_EN
      chk("out_row", WW'(out_row), WW'(exp_row));
      chk("out_col", WW'(out_col), WW'(exp_col));
`endif
    end
    if (valid_out === 1'b1) obs_q.push_back(window_out);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] pix);
    int row, col;
    @(negedge clk);
    check_outputs();
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (v) begin
      row = m_n / W;
      col = m_n % W;
      img[m_n] = pix;
      if (row >= 2 && col >= 2) begin
        exp_valid = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[(r*3+c)*DW +: DW] = img[(row-2+r)*W + (col-2+c)];
        exp_row = row - 1;
        exp_col = col - 1;
      end
      exp_done = (m_n == W*H-1);
      m_n = (m_n + 1) % (W*H);
    end
    valid_in = v;
    pixel_in = pix;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_out"}, WW'(valid_out), '0);
    chk({tag, "_frame_done"}, WW'(frame_done), '0);
    chk({tag, "_window"}, window_out, '0);
`ifdef WIN_POS_EN
    chk({tag, "_out_row"}, WW'(out_row), '0);
    chk({tag, "_out_col"}, WW'(out_col), '0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    check_zero("rst_end");
    rst = 1'b1;
    m_n = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
  endtask

  initial begin
    #3;
    rst = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Two back-to-back frames at full rate
    obs_q.delete();
    for (int n = 0; n < W*H; n++) step(1'b1, DW'(n << 8));
    for (int n = 0; n < W*H; n++) step(1'b1, DW'((n + 100) << 8));
    step(1'b0, '0);
    chk("win_count_2frames", WW'(obs_q.size()), WW'(8));
    if (obs_q.size() == 8) begin
      chk("first_win", obs_q[0], win_at(0, 0));
      chk("second_win", obs_q[1], win_at(0, 1));
      chk("last_win", obs_q[3], win_at(0, 5));
      chk("frame2_first_win", obs_q[4], win_at(100, 0));
    end

    // Same stream with random gaps and garbage on pixel_in during gaps
    obs_q.delete();
    for (int n = 0; n < W*H; n++) begin
      step(1'b1, DW'(n << 8));
      repeat ($urandom_range(0, 3)) step(1'b0, DW'($urandom));
    end
    step(1'b0, '0);
    chk("gap_win_count", WW'(obs_q.size()), WW'(4));
    if (obs_q.size() == 4) begin
      chk("gap_first_win", obs_q[0], win_at(0, 0));
      chk("gap_last_win", obs_q[3], win_at(0, 5));
    end

    // Random pixel values with random gaps across two frames
    for (int n = 0; n < 2*W*H; n++) begin
      step(1'b1, DW'($urandom));
      if ($urandom_range(0, 1) == 1) step(1'b0, DW'($urandom));
    end

    // Mid-frame reset after pixel 9, then a full restarted frame
    for (int n = 0; n < 10; n++) step(1'b1, DW'($urandom));
    do_reset();
    obs_q.delete();
    for (int n = 0; n < W*H; n++) step(1'b1, DW'(n << 8));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("restart_win_count", WW'(obs_q.size()), WW'(4));
    if (obs_q.size() == 4) chk("restart_first_win", obs_q[0], win_at(0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
